// File: rtl/maxnet_job_dispatcher.sv
// maxnet_job_dispatcher
//   Host-side driver for one Maxnet core. Collects a five-word job
//   (epsilon, a1..a4) from a valid/ready stream, holds the words as core
//   operands, pulses mx_start for one cycle and then waits (bounded by
//   TIMEOUT_CYCLES) for mx_finish. The winner value and flags are returned
//   on a valid/ready result channel.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_data/in_ready    job word stream (epsilon, a1, a2, a3, a4)
//   mx_start                     one-cycle start pulse to the core
//   mx_epsilon, mx_a1..mx_a4     registered operands, change only while loading
//   mx_finish/mx_overflow/mx_out core completion, flag and result
//   res_valid/res_ready          result handshake
//   res_data/res_overflow        captured core result, zero on timeout
//   res_timeout                  job ended without a finish
//   busy                         low only while idle (loading, no word taken)
//   job_count                    completed result handshakes, wraps
module maxnet_job_dispatcher #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mx_start,
  output logic [DATA_W-1:0] mx_epsilon,
  output logic [DATA_W-1:0] mx_a1,
  output logic [DATA_W-1:0] mx_a2,
  output logic [DATA_W-1:0] mx_a3,
  output logic [DATA_W-1:0] mx_a4,
  input  logic              mx_finish,
  input  logic              mx_overflow,
  input  logic [DATA_W-1:0] mx_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_overflow,
  output logic              res_timeout,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  job_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_TERM = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_GUARD = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  logic [2:0]        state_r, state_s;
  logic [2:0]        idx_r, idx_s;
  logic [TMR_W-1:0]  tmr_r;
  logic              accept_s;
  logic              in_ready_r, mx_start_r, res_valid_r, busy_r;
  logic              res_overflow_r, res_timeout_r;
  logic [DATA_W-1:0] eps_r, a1_r, a2_r, a3_r, a4_r, res_data_r;
  logic [CNT_W-1:0]  job_count_r;

  // in_ready_r is high exactly while in LOAD, so this is the word handshake.
  assign accept_s = in_valid & in_ready_r;

  // Next state and word index
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      ST_LOAD: begin
        if (accept_s && (idx_r == 3'd4)) begin
          state_s = ST_START;
          idx_s   = 3'd0;
        end else if (accept_s) begin
          idx_s = idx_r + 3'd1;
        end else begin
          idx_s = idx_r;
        end
      end
      ST_START: state_s = ST_GUARD;
      ST_GUARD: state_s = ST_WAIT;
      ST_WAIT: begin
        // finish has priority, but both paths leave WAIT
        if (mx_finish || (tmr_r == TMR_TERM)) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_LOAD;
        idx_s   = 3'd0;
      end
    endcase
  end

  // State, index, handshake/status outputs and completed-job counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_LOAD;
      idx_r       <= 3'd0;
      in_ready_r  <= 1'b1;
      mx_start_r  <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      job_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      // status outputs are decoded from the next state so they are registered
      in_ready_r  <= (state_s == ST_LOAD);
      mx_start_r  <= (state_s == ST_START);
      res_valid_r <= (state_s == ST_RESP);
      busy_r      <= !((state_s == ST_LOAD) && (idx_s == 3'd0));
      if (res_valid_r && res_ready) begin
        job_count_r <= job_count_r + CNT_W'(1);
      end
    end
  end

  // Operand capture; the slot is selected by the current word index
  always_ff @(posedge clk) begin
    if (rst) begin
      eps_r <= {DATA_W{1'b0}};
      a1_r  <= {DATA_W{1'b0}};
      a2_r  <= {DATA_W{1'b0}};
      a3_r  <= {DATA_W{1'b0}};
      a4_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      case (idx_r)
        3'd0:    eps_r <= in_data;
        3'd1:    a1_r  <= in_data;
        3'd2:    a2_r  <= in_data;
        3'd3:    a3_r  <= in_data;
        3'd4:    a4_r  <= in_data;
        default: eps_r <= eps_r;
      endcase
    end
  end

  // Timeout counter: cleared in GUARD, advances on every WAIT cycle without finish
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_r <= {TMR_W{1'b0}};
    end else if (state_r == ST_GUARD) begin
      tmr_r <= {TMR_W{1'b0}};
    end else if ((state_r == ST_WAIT) && !mx_finish && (tmr_r != TMR_TERM)) begin
      tmr_r <= tmr_r + TMR_W'(1);
    end
  end

  // Result capture; only WAIT samples the core, so a finish still held
  // from the previous job during START/GUARD is never taken
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_r     <= {DATA_W{1'b0}};
      res_overflow_r <= 1'b0;
      res_timeout_r  <= 1'b0;
    end else if (state_r == ST_WAIT) begin
      if (mx_finish) begin
        res_data_r     <= mx_out;
        res_overflow_r <= mx_overflow;
        res_timeout_r  <= 1'b0;
      end else if (tmr_r == TMR_TERM) begin
        res_data_r     <= {DATA_W{1'b0}};
        res_overflow_r <= 1'b0;
        res_timeout_r  <= 1'b1;
      end
    end
  end

  assign in_ready     = in_ready_r;
  assign mx_start     = mx_start_r;
  assign mx_epsilon   = eps_r;
  assign mx_a1        = a1_r;
  assign mx_a2        = a2_r;
  assign mx_a3        = a3_r;
  assign mx_a4        = a4_r;
  assign res_valid    = res_valid_r;
  assign res_data     = res_data_r;
  assign res_overflow = res_overflow_r;
  assign res_timeout  = res_timeout_r;
  assign busy         = busy_r;
  assign job_count    = job_count_r;

endmodule

// File: tb/tb_maxnet_job_dispatcher.sv
// Scoreboard bench for maxnet_job_dispatcher (TIMEOUT_CYCLES = 8).
// A core model answers each start pulse according to a per-job plan and
// pushes the expected result; a monitor pops and compares at res_valid.
module tb_maxnet_job_dispatcher;

  localparam int DW = 32;
  localparam int T  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          mx_start;
  logic [DW-1:0] mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4;
  logic          mx_finish = 1'b0;
  logic          mx_overflow = 1'b0;
  logic [DW-1:0] mx_out = '0;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_overflow;
  logic          res_timeout;
  logic          res_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] job_count;

  maxnet_job_dispatcher #(.DATA_W(DW), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mx_start(mx_start), .mx_epsilon(mx_epsilon),
    .mx_a1(mx_a1), .mx_a2(mx_a2), .mx_a3(mx_a3), .mx_a4(mx_a4),
    .mx_finish(mx_finish), .mx_overflow(mx_overflow), .mx_out(mx_out),
    .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow),
    .res_timeout(res_timeout), .res_ready(res_ready),
    .busy(busy), .job_count(job_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]      data;
    logic               ovf;
    logic               to;
    logic [4:0][DW-1:0] ops;
    int unsigned        start_cyc;
    int unsigned        lat;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               core_e, mon_e;
  int                 n_checks = 0;
  int                 n_errors = 0;
  int unsigned        cyc = 0;
  logic [CW-1:0]      exp_count = '0;
  bit                 hs_pend = 1'b0;
  bit                 front_seen = 1'b0;
  bit                 hold_low = 1'b0;
  logic [4:0][DW-1:0] cur_words = '0;
  int                 plan_dj = 1;
  logic [DW-1:0]      plan_v = '0;
  logic               plan_o = 1'b0;
  bit                 plan_stale = 1'b0;
  int                 core_dj;
  logic [DW-1:0]      core_v;
  logic               core_o;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core model: on a start pulse, decide the job outcome from the plan.
  // The finish is seen in WAIT cycle dj (1 = first WAIT cycle); WAIT lasts
  // at most T cycles and a finish on cycle T still counts.
  initial forever begin
    @(posedge clk); #1;
    if (mx_start === 1'b1 && !rst) begin
      core_dj = plan_dj;
      core_v  = plan_v;
      core_o  = plan_o;
      core_e.ops       = cur_words;
      core_e.start_cyc = cyc;
      if (core_dj <= T) begin
        core_e.data = core_v;
        core_e.ovf  = core_o;
        core_e.to   = 1'b0;
        core_e.lat  = int'(core_dj + 2);
      end else begin
        core_e.data = '0;
        core_e.ovf  = 1'b0;
        core_e.to   = 1'b1;
        core_e.lat  = T + 2;
      end
      exp_q.push_back(core_e);
      if (plan_stale) begin
        mx_finish = 1'b1; mx_out = 32'h0000_00AA; mx_overflow = 1'b1;
      end else begin
        mx_finish = 1'b0; mx_out = $urandom; mx_overflow = 1'b0;
      end
      repeat (2) begin @(posedge clk); #1; end
      for (int j = 1; j <= T; j++) begin
        if (j >= core_dj) begin
          mx_finish = 1'b1; mx_out = core_v; mx_overflow = core_o;
          break;
        end
        mx_finish = 1'b0; mx_out = $urandom; mx_overflow = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
  end

  // Result consumer
  initial forever begin
    @(posedge clk); #1;
    res_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hs_pend = 1'b0;
    end else begin
      if (hs_pend) begin
        hs_pend = 1'b0;
        chk(job_count == exp_count, "job_count", 32'(job_count), 32'(exp_count));
        chk(res_valid == 1'b0, "res_valid_drop", 32'(res_valid), 32'd0);
      end
      if (res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_result", res_data, 32'd0);
        end else begin
          mon_e = exp_q[0];
          chk(res_data == mon_e.data, "res_data", res_data, mon_e.data);
          chk(res_overflow == mon_e.ovf, "res_overflow", 32'(res_overflow), 32'(mon_e.ovf));
          chk(res_timeout == mon_e.to, "res_timeout", 32'(res_timeout), 32'(mon_e.to));
          chk(in_ready == 1'b0, "in_ready_in_resp", 32'(in_ready), 32'd0);
          chk(busy == 1'b1, "busy_in_resp", 32'(busy), 32'd1);
          chk(mx_epsilon == mon_e.ops[0] && mx_a1 == mon_e.ops[1] && mx_a2 == mon_e.ops[2] &&
              mx_a3 == mon_e.ops[3] && mx_a4 == mon_e.ops[4], "operand_hold", mx_a1, mon_e.ops[1]);
          if (!front_seen) begin
            front_seen = 1'b1;
            chk(cyc - mon_e.start_cyc == mon_e.lat, "latency", cyc - mon_e.start_cyc, mon_e.lat);
          end
          if (res_ready) begin
            void'(exp_q.pop_front());
            exp_count++;
            hs_pend = 1'b1;
            front_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic set_plan(input int dj, input logic [DW-1:0] v, input logic o, input bit stale);
    plan_dj = dj; plan_v = v; plan_o = o; plan_stale = stale;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 5; i++) cur_words[i] = $urandom;
  endtask

  // Send the first n words of cur_words; for a full job check the start pulse.
  task automatic send_job(input int n, input bit gaps);
    int w = 0;
    int budget = 0;
    bit ph = 1'b1;
    bit acc;
    while (w < n && budget < 300) begin
      in_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      in_data = cur_words[w];
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      budget++;
      if (acc) w++;
    end
    in_valid = 1'b0;
    in_data = '0;
    if (w < n) begin
      chk(1'b0, "load_timeout", 32'(w), 32'(n));
    end else if (n == 5) begin
      chk(mx_start == 1'b1, "mx_start_pulse", 32'(mx_start), 32'd1);
      chk(mx_epsilon == cur_words[0] && mx_a1 == cur_words[1] && mx_a2 == cur_words[2] &&
          mx_a3 == cur_words[3] && mx_a4 == cur_words[4], "operand_load", mx_a2, cur_words[2]);
      chk(busy == 1'b1, "busy_after_load", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk(mx_start == 1'b0, "mx_start_single", 32'(mx_start), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_q.size() != 0 || hs_pend) && b < 400) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 400) chk(1'b0, "idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk(in_ready == 1'b1, {tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk(mx_start == 1'b0, {tag, "_mx_start"}, 32'(mx_start), 32'd0);
    chk(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'd0);
    chk(res_valid == 1'b0, {tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk(res_data == '0 && res_overflow == 1'b0 && res_timeout == 1'b0, {tag, "_res"}, res_data, 32'd0);
    chk(job_count == '0, {tag, "_job_count"}, 32'(job_count), 32'd0);
    chk(mx_epsilon == '0 && mx_a1 == '0 && mx_a2 == '0 && mx_a3 == '0 && mx_a4 == '0,
        {tag, "_operands"}, mx_epsilon | mx_a1 | mx_a2 | mx_a3 | mx_a4, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int b;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("por");

    // Basic job, finish 6 cycles after start
    cur_words = {32'd7, 32'd3, 32'd9, 32'd5, 32'h10};
    set_plan(5, 32'd9, 1'b0, 1'b0);
    send_job(5, 1'b0);
    chk(mx_a2 == 32'd9, "basic_a2", mx_a2, 32'd9);
    wait_idle();

    // Input gaps, then 10 cycles of result backpressure; second job queued behind it
    rand_words();
    set_plan(3, $urandom, 1'b0, 1'b0);
    hold_low = 1'b1;
    send_job(5, 1'b1);
    b = 0;
    while (res_valid !== 1'b1 && b < 50) begin @(posedge clk); #1; b++; end
    if (b >= 50) chk(1'b0, "bp_res_valid_timeout", 32'(b), 32'd50);
    repeat (10) begin @(posedge clk); #1; end
    hold_low = 1'b0;
    rand_words();
    set_plan(2, $urandom, 1'b1, 1'b0);
    send_job(5, 1'b1);
    wait_idle();

    // Core never finishes
    rand_words();
    set_plan(T + 5, $urandom, 1'b0, 1'b0);
    send_job(5, 1'b0);
    wait_idle();

    // Stale finish through START/GUARD, real result in first WAIT cycle
    rand_words();
    set_plan(1, 32'h0000_0055, 1'b0, 1'b1);
    send_job(5, 1'b0);
    wait_idle();

    // Finish with overflow exactly on the timeout terminal cycle
    rand_words();
    set_plan(T, $urandom, 1'b1, 1'b0);
    send_job(5, 1'b0);
    wait_idle();

    // Reset after 3 words
    rand_words();
    send_job(3, 1'b0);
    chk(busy == 1'b1, "busy_partial", 32'(busy), 32'd1);
    pulse_reset();
    chk_reset_state("rst_load");
    exp_count = '0;
    rand_words();
    set_plan(4, $urandom, 1'b0, 1'b0);
    send_job(5, 1'b0);
    wait_idle();

    // Reset in WAIT
    rand_words();
    set_plan(T + 5, $urandom, 1'b0, 1'b0);
    send_job(5, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    pulse_reset();
    chk_reset_state("rst_wait");
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_count = '0;
    repeat (15) begin @(posedge clk); #1; end
    rand_words();
    set_plan(2, $urandom, 1'b1, 1'b0);
    send_job(5, 1'b0);
    wait_idle();

    // Random jobs
    for (int k = 0; k < 40; k++) begin
      rand_words();
      set_plan(int'($urandom_range(1, T + 2)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      send_job(5, 1'($urandom_range(0, 1)));
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
